// File: rtl/mem_bist_initiator.sv
// Memory BIST initiator: writes seed^addr to every address over a valid/ready link,
// reads it back and counts mismatches. MEM_BIST_INV_PASS_EN adds an inverted write/read pass.
module mem_bist_initiator #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

`ifdef MEM_BIST_INV_PASS_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ      = 3'd2,
        DONE      = 3'd3,
        WRITE_INV = 3'd4,
        READ_INV  = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;
`endif

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] seed_reg;

    logic                  handshake;
    logic                  last_addr;
    logic                  inv_phase;
    logic                  mismatch;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [DATA_WIDTH-1:0] next_wdata;

    always_comb begin
        handshake = valid && ready;
        last_addr = (addr == ADDR_WIDTH'(DEPTH - 1));
        addr_inc  = addr + ADDR_WIDTH'(1);
        inv_phase = 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
        inv_phase = (state_reg == WRITE_INV) || (state_reg == READ_INV);
`endif
        exp_data   = seed_reg ^ DATA_WIDTH'(addr) ^ {DATA_WIDTH{inv_phase}};
        next_wdata = seed_reg ^ DATA_WIDTH'(addr_inc) ^ {DATA_WIDTH{inv_phase}};
        mismatch   = (rdata != exp_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            seed_reg  <= '0;
            valid     <= 1'b0;
            wr_rd     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
        end else begin
            // Read-phase scoring is shared by the normal and inverted passes
            if (handshake && !wr_rd && mismatch) begin
                if (err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
                if (err_count == 8'd0)
                    fail_addr <= addr;
            end

            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= WRITE;
                        seed_reg  <= seed;
                        err_count <= '0;
                        fail_addr <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        valid     <= 1'b1;
                        wr_rd     <= 1'b1;
                        addr      <= '0;
                        wdata     <= seed;
                    end
                end
                WRITE: begin
                    if (handshake) begin
                        if (last_addr) begin
                            state_reg <= READ;
                            wr_rd     <= 1'b0;
                            addr      <= '0;
                            wdata     <= '0;
                        end else begin
                            addr  <= addr_inc;
                            wdata <= next_wdata;
                        end
                    end
                end
                READ: begin
                    if (handshake) begin
                        if (last_addr) begin
                            addr <= '0;
`ifdef MEM_BIST_INV_PASS_EN
                            state_reg <= WRITE_INV;
                            wr_rd     <= 1'b1;
                            wdata     <= ~seed_reg;
`else
                            state_reg <= DONE;
                            valid     <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (err_count == 8'd0) && !mismatch;
`endif
                        end else begin
                            addr <= addr_inc;
                        end
                    end
                end
`ifdef MEM_BIST_INV_PASS_EN
                WRITE_INV: begin
                    if (handshake) begin
                        if (last_addr) begin
                            state_reg <= READ_INV;
                            wr_rd     <= 1'b0;
                            addr      <= '0;
                            wdata     <= '0;
                        end else begin
                            addr  <= addr_inc;
                            wdata <= next_wdata;
                        end
                    end
                end
                READ_INV: begin
                    if (handshake) begin
                        if (last_addr) begin
                            state_reg <= DONE;
                            addr      <= '0;
                            valid     <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (err_count == 8'd0) && !mismatch;
                        end else begin
                            addr <= addr_inc;
                        end
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Self-checking bench for mem_bist_initiator: behavioural memory responder with
// per-address read corruption, transfer log checked against the expected sweep.
module tb_mem_bist_initiator;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
`ifdef MEM_BIST_INV_PASS_EN
    localparam int NPH = 2;
`else
    localparam int NPH = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] seed;
    logic          valid;
    logic          wr_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          done;
    logic          pass;
    logic [7:0]    err_count;
    logic [AW-1:0] fail_addr;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] corrupt [DEPTH];
    int            wr_cnt  [DEPTH];
    logic [20:0]   hs_q[$];

    always #5 clk = ~clk;

    mem_bist_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_addr(fail_addr)
    );

    assign rdata = (valid && !wr_rd) ? (mem[addr] ^ corrupt[addr]) : '0;

    // Inputs change just after rising edges, so the negedge sees what the next edge will accept
    always @(negedge clk) begin
        if (rst === 1'b0 && valid === 1'b1 && ready === 1'b1) begin
            hs_q.push_back({wr_rd, addr, wdata});
            if (wr_rd) begin
                mem[addr]    = wdata;
                wr_cnt[addr] = wr_cnt[addr] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready=1, 1: random ready, 2: stall write addr 7, 3: start pulse at read addr 4
    task automatic run(input logic [DW-1:0] s, input int mode, input int budget, output int cyc);
        bit stalled = 0;
        bit pulsed  = 0;
        hs_q.delete();
        for (int i = 0; i < DEPTH; i++) wr_cnt[i] = 0;
        @(posedge clk); #1;
        seed  = s;
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seed  = DW'($urandom);
        chk("busy_after_start", busy, 1);
        chk("valid_after_start", valid, 1);
        chk("done_after_start", done, 0);
        chk("first_addr", addr, 0);
        chk("first_wdata", wdata, s);
        cyc = 1;
        while (done !== 1'b1 && cyc < budget) begin
            start = 1'b0;
            ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mode == 3 && !pulsed && valid && !wr_rd && addr == 4'd4) begin
                start  = 1'b1;
                pulsed = 1;
            end
            if (mode == 2 && !stalled && valid && wr_rd && addr == 4'd7) begin
                stalled = 1;
                for (int i = 0; i < 4; i++) begin
                    ready = (i == 3);
                    @(negedge clk);
                    chk("stall_addr", addr, 7);
                    chk("stall_wdata", wdata, 16'hA5A2);
                    chk("stall_valid", valid, 1);
                    @(posedge clk); #1;
                    cyc++;
                end
                continue;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("done_within_budget", done, 1);
    endtask

    // Expected transfer k: phase k/DEPTH, address k%DEPTH; even phases write, later pair inverted
    task automatic check_seq(input logic [DW-1:0] s);
        int total = 2 * DEPTH * NPH;
        int n;
        chk("handshake_count", hs_q.size(), total);
        n = (hs_q.size() < total) ? hs_q.size() : total;
        for (int k = 0; k < n; k++) begin
            int            ph = k / DEPTH;
            int            a  = k % DEPTH;
            logic          wr = (ph % 2 == 0);
            logic [DW-1:0] d  = s ^ DW'(a);
            if (ph >= 2) d = ~d;
            if (!wr) d = '0;
            chk($sformatf("xfer%0d", k), hs_q[k], {wr, AW'(a), d});
        end
    endtask

    task automatic check_result();
        int nbad  = 0;
        int first = -1;
        int exp_err;
        for (int a = 0; a < DEPTH; a++) begin
            if (corrupt[a] != '0) begin
                nbad++;
                if (first < 0) first = a;
            end
        end
        exp_err = nbad * NPH;
        if (exp_err > 255) exp_err = 255;
        chk("err_count", err_count, exp_err);
        chk("fail_addr", fail_addr, (first < 0) ? 0 : first);
        chk("pass", pass, (nbad == 0));
        chk("done", done, 1);
        chk("busy_at_done", busy, 0);
        chk("valid_at_done", valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_wr_rd"}, wr_rd, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_fail"}, fail_addr, 0);
    endtask

    initial begin
        int cyc;
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        seed  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            corrupt[i] = '0;
            mem[i]     = '0;
            wr_cnt[i]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Abort mid-write at address 5
        @(posedge clk); #1;
        seed = 16'h1234; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40 && !(valid && wr_rd && addr == 4'd5); i++) begin
            @(posedge clk); #1;
        end
        chk("reached_addr5", addr, 5);
        #2 rst = 1'b1;
        #1 check_all_zero("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        $display("step: reset mid-write checked");

        // Clean run, ready tied high: back-to-back transfers and exact latency
        run(16'hA5A5, 0, 200, cyc);
        chk("latency_cycles", cyc, 2 * DEPTH * NPH + 1);
        check_seq(16'hA5A5);
        check_result();
        $display("step: clean run seed=a5a5 cycles=%0d", cyc);

        // Stall at write address 7
        run(16'hA5A5, 2, 400, cyc);
        check_seq(16'hA5A5);
        chk("wr_cnt_addr7", wr_cnt[7], NPH);
        check_result();
        $display("step: stall at write addr 7");

        // Corrupted reads at 3 and 9, random ready
        corrupt[3] = 16'h0001;
        corrupt[9] = 16'h0001;
        run(16'hA5A5, 1, 600, cyc);
        check_seq(16'hA5A5);
        check_result();
        $display("step: corrupt addr 3,9 err=%0d fail=%0d", err_count, fail_addr);

        // Start pulse during the read sweep is ignored
        corrupt[3] = '0;
        corrupt[9] = '0;
        run(16'h0F0F, 3, 200, cyc);
        check_seq(16'h0F0F);
        check_result();
        $display("step: start pulse at read addr 4");

        // Every read corrupted, twice back to back from DONE
        for (int i = 0; i < DEPTH; i++) corrupt[i] = 16'h0001;
        for (int r = 0; r < 2; r++) begin
            run(16'hC3C3, 0, 200, cyc);
            check_result();
            $display("step: all-corrupt run %0d err=%0d", r, err_count);
        end

        // Random seeds, random corruption, random ready
        for (int r = 0; r < 3; r++) begin
            logic [DW-1:0] s = DW'($urandom);
            for (int i = 0; i < DEPTH; i++)
                corrupt[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(1, 65535)) : '0;
            run(s, 1, 800, cyc);
            check_seq(s);
            check_result();
            $display("step: random run seed=%0h err=%0d pass=%0d", s, err_count, pass);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
